rgb_led_fader: RTL and testbench

- Downstream of the board's colour-sequencing counter stage; consumes its 3-bit active-low RGB colour code (110 G, 101 R, 011 B).
- Drives the on-board RGB LED pins with PWM so each colour change is a linear crossfade instead of a hard step.
- Each channel ramps its brightness independently toward the level requested by the incoming code.
- Sits between the colour sequencer and the top-level LED pins; same single clock domain.

---
 rtl/rgb_led_fader.sv | 119 +++++++++++
 tb/tb_rgb_led_fader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rgb_led_fader.sv
// PWM crossfader for the on-board RGB LED: each channel ramps linearly toward the
// full-on or full-off level requested by the active-low colour code.
module rgb_led_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 46875
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] color_in,
    input  logic       en,
    output logic [2:0] led_out,
    output logic       busy
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam int                  PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } state_t;

    logic [2:0]          color_q;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty [3];
    state_t              state [3];
    logic [2:0]          target;
    logic [2:0]          lit;
    logic [2:0]          ramping;

    // Saturating one-step move of a duty value toward the requested end.
    function automatic logic [PWM_BITS-1:0] step_duty(input logic [PWM_BITS-1:0] d,
                                                      input logic up);
        logic [PWM_BITS-1:0] r;
        r = d;
        if (up && d != DUTY_MAX)
            r = d + PWM_BITS'(1);
        else if (!up && d != '0)
            r = d - PWM_BITS'(1);
        return r;
    endfunction

    function automatic state_t classify(input logic [PWM_BITS-1:0] d, input logic up);
        state_t s;
        if (up)
            s = (d == DUTY_MAX) ? ON : RISE;
        else
            s = (d == '0) ? OFF : FALL;
        return s;
    endfunction

    assign tick = en && (presc == PRE_LAST);

    always_comb begin
        target  = '0;
        lit     = '0;
        ramping = '0;
        for (int c = 0; c < 3; c++) begin
            target[c]  = ~color_q[c];
            lit[c]     = (duty[c] == DUTY_MAX) || (pwm_cnt < duty[c]);
            ramping[c] = (state[c] == RISE) || (state[c] == FALL);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            color_q <= 3'b111;
        end else begin
            color_q <= color_in;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (en) begin
            presc   <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Next state is taken from the post-step duty, so a direction change and a
    // tick in the same cycle step in the new direction, and the end states are
    // entered on the very edge the duty saturates.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < 3; c++) begin
                duty[c]  <= '0;
                state[c] <= OFF;
            end
        end else if (en) begin
            for (int c = 0; c < 3; c++) begin
                logic [PWM_BITS-1:0] nd;
                nd = tick ? step_duty(duty[c], target[c]) : duty[c];
                duty[c]  <= nd;
                state[c] <= classify(nd, target[c]);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_out <= 3'b111;
            busy    <= 1'b0;
        end else if (en) begin
            led_out <= ~lit;
            busy    <= |ramping;
        end else begin
            led_out <= 3'b111;
        end
    end

endmodule

// File: tb/tb_rgb_led_fader.sv
// Directed bench for rgb_led_fader: steady-state vector table plus hand-written
// ramp, PWM-period, enable-freeze and asynchronous-reset sequences.
module tb_rgb_led_fader;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [2:0] color_in, color2;
    logic       en, en2;
    logic [2:0] led_out, led2;
    logic       busy, busy2;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    rgb_led_fader #(.PWM_BITS(8), .STEP_CYCLES(4)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .color_in (color_in),
        .en       (en),
        .led_out  (led_out),
        .busy     (busy)
    );

    rgb_led_fader #(.PWM_BITS(8), .STEP_CYCLES(1024)) dut2 (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .color_in (color2),
        .en       (en2),
        .led_out  (led2),
        .busy     (busy2)
    );

    typedef struct {
        logic [2:0] color;
        logic       en;
        int         waits;
        logic       chk_led;
        logic [2:0] led;
        logic       busy;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int n, prev, d, bad, lows;

        //        color   en waits  chk  led     busy
        vt[0]  = '{3'b111, 1, 2000, 1, 3'b111, 0};
        vt[1]  = '{3'b110, 1, 2,    0, 3'b111, 0};
        vt[2]  = '{3'b110, 1, 1,    0, 3'b111, 1};
        vt[3]  = '{3'b110, 1, 1100, 1, 3'b110, 0};
        vt[4]  = '{3'b111, 1, 1100, 1, 3'b111, 0};
        vt[5]  = '{3'b101, 1, 1100, 1, 3'b101, 0};
        vt[6]  = '{3'b011, 1, 1100, 1, 3'b011, 0};
        vt[7]  = '{3'b000, 1, 1100, 1, 3'b000, 0};
        vt[8]  = '{3'b000, 0, 1,    1, 3'b111, 0};
        vt[9]  = '{3'b000, 1, 1,    1, 3'b000, 0};
        vt[10] = '{3'b111, 1, 100,  0, 3'b111, 1};
        vt[11] = '{3'b111, 0, 500,  1, 3'b111, 1};
        vt[12] = '{3'b111, 1, 1100, 1, 3'b111, 0};

        sys_rst_n = 1'b0;
        color_in  = 3'b111;
        en        = 1'b1;
        color2    = 3'b011;
        en2       = 1'b1;
        step(3);
        check("reset_led", led_out, 3'b111);
        check("reset_busy", busy, 0);
        check("reset_led2", led2, 3'b111);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            color_in = vt[i].color;
            en       = vt[i].en;
            step(vt[i].waits);
            if (vt[i].chk_led)
                check($sformatf("vec%0d_led", i), led_out, vt[i].led);
            check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
        end

        // Ramp channel 1 to 100, then reverse and watch the fall.
        color_in = 3'b101;
        n = 0;
        while (dut.duty[1] != 100 && n < 600) begin step(1); n++; end
        check("t3_reach100", dut.duty[1], 100);
        color_in = 3'b111;
        prev = 100; bad = 0; n = 0;
        while (dut.duty[1] != 0 && n < 600) begin
            step(1); n++;
            d = dut.duty[1];
            if (d > prev || prev - d > 1) bad++;
            prev = d;
        end
        check("t3_monotonic", bad, 0);
        check("t3_fall_cycles_in_398_402", (n >= 398 && n <= 402), 1);
        check("t3_busy_at_zero", busy, 1);
        step(1);
        check("t3_busy_cleared", busy, 0);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (led_out[1] !== 1'b1) bad++;
        end
        check("t3_led1_dark", bad, 0);

        // One full PWM period of channel 2 at duty 64 on the slow instance.
        n = 0;
        while (dut2.duty[2] != 64 && n < 70000) begin step(1); n++; end
        check("t4_reach64", dut2.duty[2], 64);
        n = 0;
        while (dut2.pwm_cnt != 0 && n < 300) begin step(1); n++; end
        check("t4_pwm_aligned", dut2.pwm_cnt, 0);
        lows = 0; bad = 0;
        for (int i = 1; i <= 256; i++) begin
            step(1);
            if (led2[2] == 1'b0) lows++;
            if ((led2[2] == 1'b0) != (i <= 64)) bad++;
        end
        check("t4_low_cycles", lows, 64);
        check("t4_contiguous", bad, 0);
        check("t4_duty_held", dut2.duty[2], 64);

        // Freeze channel 0 at duty 50 with en low, then resume.
        color_in = 3'b110;
        n = 0;
        while (dut.duty[0] != 50 && n < 400) begin step(1); n++; end
        check("t5_reach50", dut.duty[0], 50);
        en = 1'b0;
        step(1);
        check("t5_blank_next_edge", led_out, 3'b111);
        step(499);
        check("t5_duty_frozen", dut.duty[0], 50);
        check("t5_led_blank", led_out, 3'b111);
        check("t5_busy_held", busy, 1);
        en = 1'b1;
        n = 0;
        while (dut.duty[0] == 50 && n < 20) begin step(1); n++; end
        check("t5_resume51", dut.duty[0], 51);
        n = 0;
        while (dut.duty[0] == 51 && n < 20) begin step(1); n++; end
        check("t5_resume52", dut.duty[0], 52);

        // Asynchronous reset between clock edges while ramping.
        step(1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t6_async_led", led_out, 3'b111);
        check("t6_async_busy", busy, 0);
        check("t6_async_duty", dut.duty[0], 0);
        #1;
        sys_rst_n = 1'b1;
        step(20);
        check("t6_restart_duty", dut.duty[0], 5);
        check("t6_restart_busy", busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
